// File: rtl/cv32e40p_rf_wb_arbiter.sv
// Small power-of-two FIFO for writeback requests; an entry pushed in one cycle is at
// the head the next cycle (no bypass). full_o depends only on stored occupancy.
module cv32e40p_rf_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_int,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q;
  logic [PW:0]      rd_ptr_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + {{PW{1'b0}}, 1'b1};
      if (pop_i)  rd_ptr_q <= rd_ptr_q + {{PW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_int) begin
    if (push_i) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
  end
endmodule

// Register-file writeback arbiter: ALU (unbuffered) plus buffered LSU/APU onto two
// write ports, registered outputs one cycle after selection; LSU/APU ready = FIFO not full.
module cv32e40p_rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk_int,
  input  logic                  rst_n,
  input  logic                  ex_valid_i,
  input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic                  apu_valid_i,
  output logic                  apu_ready_o,
  input  logic [ADDR_WIDTH-1:0] apu_waddr_i,
  input  logic [DATA_WIDTH-1:0] apu_wdata_i,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_b_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  pending_o,
  output logic [15:0]           wait_cnt_o
);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {SRC_NONE, SRC_E, SRC_L, SRC_P} src_e;

  logic [EW-1:0] l_head, p_head, ex_ent, a_ent, b_ent;
  logic          l_empty, l_full, p_empty, p_full;
  logic          l_vld, p_vld, l_pop, p_pop;
  logic          win_l, collide, wait_inc;
  src_e          win_src, los_src, a_src, b_src, b_iss;
  logic          rr_q, rr_d;
  logic          we_a_d, we_b_d;
  logic          we_a_q, we_b_q;
  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_b_q;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_b_q;
  logic [15:0]           wait_cnt_q;

  assign lsu_ready_o = !l_full;
  assign apu_ready_o = !p_full;
  assign l_vld       = !l_empty;
  assign p_vld       = !p_empty;
  assign ex_ent      = {ex_waddr_i, ex_wdata_i};

  cv32e40p_rf_wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_lsu_fifo (
    .clk_int (clk_int),
    .rst_n   (rst_n),
    .push_i  (lsu_valid_i && lsu_ready_o),
    .data_i  ({lsu_waddr_i, lsu_wdata_i}),
    .pop_i   (l_pop),
    .data_o  (l_head),
    .empty_o (l_empty),
    .full_o  (l_full)
  );

  cv32e40p_rf_wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_apu_fifo (
    .clk_int (clk_int),
    .rst_n   (rst_n),
    .push_i  (apu_valid_i && apu_ready_o),
    .data_i  ({apu_waddr_i, apu_wdata_i}),
    .pop_i   (p_pop),
    .data_o  (p_head),
    .empty_o (p_empty),
    .full_o  (p_full)
  );

  function automatic logic [EW-1:0] pick(src_e s, logic [EW-1:0] e,
                                         logic [EW-1:0] l, logic [EW-1:0] p);
    case (s)
      SRC_E:   return e;
      SRC_L:   return l;
      SRC_P:   return p;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    // rr_q == 0 favours the LSU when both buffered heads compete.
    win_l   = l_vld && (!p_vld || !rr_q);
    win_src = win_l ? SRC_L : SRC_P;
    los_src = win_l ? SRC_P : SRC_L;
    a_src   = SRC_NONE;
    b_src   = SRC_NONE;
    if (ex_valid_i) begin
      a_src = SRC_E;
      if (l_vld || p_vld) b_src = win_src;
    end else begin
      if (l_vld || p_vld) a_src = win_src;
      if (l_vld && p_vld) b_src = los_src;
    end

    a_ent   = pick(a_src, ex_ent, l_head, p_head);
    b_ent   = pick(b_src, ex_ent, l_head, p_head);
    collide = (a_src != SRC_NONE) && (b_src != SRC_NONE) &&
              (a_ent[EW-1:DATA_WIDTH] == b_ent[EW-1:DATA_WIDTH]);
    b_iss   = collide ? SRC_NONE : b_src;

    // Zero-address heads are consumed like real writes but never raise we.
    l_pop    = (a_src == SRC_L) || (b_iss == SRC_L);
    p_pop    = (a_src == SRC_P) || (b_iss == SRC_P);
    wait_inc = (l_vld && !l_pop) || (p_vld && !p_pop);

    rr_d = rr_q;
    if (l_vld && p_vld && (!ex_valid_i || !collide)) rr_d = !rr_q;

    we_a_d = (a_src != SRC_NONE) && (a_ent[EW-1:DATA_WIDTH] != '0);
    we_b_d = (b_iss != SRC_NONE) && (b_ent[EW-1:DATA_WIDTH] != '0);
  end

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= 1'b0;
      we_a_q     <= 1'b0;
      we_b_q     <= 1'b0;
      waddr_a_q  <= '0;
      wdata_a_q  <= '0;
      waddr_b_q  <= '0;
      wdata_b_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      rr_q   <= rr_d;
      we_a_q <= we_a_d;
      we_b_q <= we_b_d;
      if (we_a_d) begin
        waddr_a_q <= a_ent[EW-1:DATA_WIDTH];
        wdata_a_q <= a_ent[DATA_WIDTH-1:0];
      end
      if (we_b_d) begin
        waddr_b_q <= b_ent[EW-1:DATA_WIDTH];
        wdata_b_q <= b_ent[DATA_WIDTH-1:0];
      end
      if (wait_inc && (wait_cnt_q != 16'hFFFF)) wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  assign we_a_o     = we_a_q;
  assign waddr_a_o  = waddr_a_q;
  assign wdata_a_o  = wdata_a_q;
  assign we_b_o     = we_b_q;
  assign waddr_b_o  = waddr_b_q;
  assign wdata_b_o  = wdata_b_q;
  assign pending_o  = l_vld || p_vld;
  assign wait_cnt_o = wait_cnt_q;
endmodule

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
// Directed cycle checks plus a per-requester ordering scoreboard for the writeback arbiter.
module tb_cv32e40p_rf_wb_arbiter;
  logic        clk_int = 1'b0;
  logic        rst_n   = 1'b0;
  logic        ex_valid_i = 1'b0, lsu_valid_i = 1'b0, apu_valid_i = 1'b0;
  logic [5:0]  ex_waddr_i = '0, lsu_waddr_i = '0, apu_waddr_i = '0;
  logic [31:0] ex_wdata_i = '0, lsu_wdata_i = '0, apu_wdata_i = '0;
  logic        lsu_ready_o, apu_ready_o, we_a_o, we_b_o, pending_o;
  logic [5:0]  waddr_a_o, waddr_b_o;
  logic [31:0] wdata_a_o, wdata_b_o;
  logic [15:0] wait_cnt_o;

  int n_vec = 0;
  int n_err = 0;
  bit sb_en = 1'b0;
  logic [37:0] exp_e[$], exp_l[$], exp_p[$];

  always #5 clk_int = ~clk_int;

  cv32e40p_rf_wb_arbiter dut (
    .clk_int(clk_int), .rst_n(rst_n),
    .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .apu_valid_i(apu_valid_i), .apu_ready_o(apu_ready_o),
    .apu_waddr_i(apu_waddr_i), .apu_wdata_i(apu_wdata_i),
    .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
    .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
    .pending_o(pending_o), .wait_cnt_o(wait_cnt_o)
  );

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record expected writes at acceptance time, then advance one clock.
  task automatic tick();
    if (sb_en) begin
      if (ex_valid_i && ex_waddr_i != 0) exp_e.push_back({ex_waddr_i, ex_wdata_i});
      if (lsu_valid_i && lsu_ready_o && lsu_waddr_i != 0) exp_l.push_back({lsu_waddr_i, lsu_wdata_i});
      if (apu_valid_i && apu_ready_o && apu_waddr_i != 0) exp_p.push_back({apu_waddr_i, apu_wdata_i});
    end
    @(posedge clk_int);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid_i = 0; lsu_valid_i = 0; apu_valid_i = 0;
    ex_waddr_i = 0; lsu_waddr_i = 0; apu_waddr_i = 0;
    ex_wdata_i = 0; lsu_wdata_i = 0; apu_wdata_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    exp_e.delete(); exp_l.delete(); exp_p.delete();
    repeat (2) @(posedge clk_int);
    #1 rst_n = 1;
  endtask

  task automatic sb_pop(string port, logic [5:0] a, logic [31:0] d);
    logic [37:0] exp;
    bit ok;
    ok = 0;
    exp = '0;
    check_eq({port, "_addr_nonzero"}, a != 0, 1);
    case (d[31:28])
      4'hE: begin ok = exp_e.size() > 0; if (ok) exp = exp_e.pop_front(); end
      4'h1: begin ok = exp_l.size() > 0; if (ok) exp = exp_l.pop_front(); end
      4'h2: begin ok = exp_p.size() > 0; if (ok) exp = exp_p.pop_front(); end
      default: ok = 0;
    endcase
    check_eq({port, "_write_expected"}, ok, 1);
    if (ok) check_eq({port, "_write_order"}, {a, d}, exp);
  endtask

  always @(negedge clk_int) begin
    if (sb_en && rst_n) begin
      if (we_a_o) sb_pop("portA", waddr_a_o, wdata_a_o);
      if (we_b_o) sb_pop("portB", waddr_b_o, wdata_b_o);
    end
  end

  initial begin
    bit acc_l, acc_p;
    int seq_l, seq_p;

    // Reset values, observed while reset is held.
    repeat (2) @(posedge clk_int);
    #1;
    check_eq("rst_we_a", we_a_o, 0);
    check_eq("rst_we_b", we_b_o, 0);
    check_eq("rst_waddr_a", waddr_a_o, 0);
    check_eq("rst_wdata_b", wdata_b_o, 0);
    check_eq("rst_wait", wait_cnt_o, 0);
    check_eq("rst_pending", pending_o, 0);
    check_eq("rst_lsu_rdy", lsu_ready_o, 1);
    check_eq("rst_apu_rdy", apu_ready_o, 1);
    rst_n = 1;

    // ALU-only write: registered one cycle later on port A, value then held.
    ex_valid_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'hA5A5A5A5;
    tick();
    ex_valid_i = 0;
    check_eq("e_we_a", we_a_o, 1);
    check_eq("e_waddr_a", waddr_a_o, 5);
    check_eq("e_wdata_a", wdata_a_o, 32'hA5A5A5A5);
    check_eq("e_we_b", we_b_o, 0);
    tick();
    check_eq("e_idle_we_a", we_a_o, 0);
    check_eq("e_hold_waddr_a", waddr_a_o, 5);

    // Three-way contention, RR starting on LSU.
    do_reset();
    lsu_valid_i = 1; lsu_waddr_i = 7; lsu_wdata_i = 32'h7777;
    apu_valid_i = 1; apu_waddr_i = 9; apu_wdata_i = 32'h9999;
    tick();
    lsu_valid_i = 0; apu_valid_i = 0;
    ex_valid_i = 1; ex_waddr_i = 3; ex_wdata_i = 32'h3333;
    check_eq("c3_pending", pending_o, 1);
    tick();
    check_eq("c3_1_waddr_a", {we_a_o, waddr_a_o}, {1'b1, 6'd3});
    check_eq("c3_1_waddr_b", {we_b_o, waddr_b_o}, {1'b1, 6'd7});
    check_eq("c3_1_wdata_b", wdata_b_o, 32'h7777);
    check_eq("c3_1_wait", wait_cnt_o, 1);
    tick();
    ex_valid_i = 0;
    check_eq("c3_2_waddr_a", {we_a_o, waddr_a_o}, {1'b1, 6'd3});
    check_eq("c3_2_waddr_b", {we_b_o, waddr_b_o}, {1'b1, 6'd9});
    check_eq("c3_2_wdata_b", wdata_b_o, 32'h9999);
    check_eq("c3_2_wait", wait_cnt_o, 1);
    check_eq("c3_2_pending", pending_o, 0);
    tick();
    check_eq("c3_idle_we", {we_a_o, we_b_o}, 2'b00);
    check_eq("c3_hold_waddr_b", waddr_b_o, 9);

    // Same-address collision: LSU head held back, issues next cycle.
    do_reset();
    lsu_valid_i = 1; lsu_waddr_i = 4; lsu_wdata_i = 32'h4444;
    tick();
    lsu_valid_i = 0;
    ex_valid_i = 1; ex_waddr_i = 4; ex_wdata_i = 32'hE4;
    tick();
    check_eq("col_a", {we_a_o, waddr_a_o, wdata_a_o}, {1'b1, 6'd4, 32'hE4});
    check_eq("col_we_b", we_b_o, 0);
    check_eq("col_pending", pending_o, 1);
    ex_waddr_i = 6; ex_wdata_i = 32'hE6;
    tick();
    ex_valid_i = 0;
    check_eq("col_next_a", {we_a_o, waddr_a_o}, {1'b1, 6'd6});
    check_eq("col_next_b", {we_b_o, waddr_b_o, wdata_b_o}, {1'b1, 6'd4, 32'h4444});
    check_eq("col_pending2", pending_o, 0);
    check_eq("col_wait", wait_cnt_o, 1);

    // Zero address: consumed silently.
    do_reset();
    lsu_valid_i = 1; lsu_waddr_i = 0; lsu_wdata_i = 32'h1234;
    tick();
    lsu_valid_i = 0;
    check_eq("z_pending", pending_o, 1);
    tick();
    check_eq("z_we", {we_a_o, we_b_o}, 2'b00);
    check_eq("z_pending_clr", pending_o, 0);
    check_eq("z_wait", wait_cnt_o, 0);

    // Backpressure with APU winning RR; order checked by scoreboard.
    do_reset();
    sb_en = 1;
    lsu_valid_i = 1; lsu_waddr_i = 1; lsu_wdata_i = 32'h1000_0001;
    apu_valid_i = 1; apu_waddr_i = 2; apu_wdata_i = 32'h2000_0002;
    tick();
    lsu_valid_i = 0; apu_valid_i = 0;
    tick();
    tick();
    ex_valid_i = 1; ex_waddr_i = 15; ex_wdata_i = 32'hE000_000F;
    apu_valid_i = 1; apu_waddr_i = 10; apu_wdata_i = 32'h2000_0010;
    lsu_valid_i = 1; lsu_waddr_i = 20; lsu_wdata_i = 32'h1000_0020;
    tick();
    apu_waddr_i = 11; apu_wdata_i = 32'h2000_0011;
    lsu_waddr_i = 21; lsu_wdata_i = 32'h1000_0021;
    tick();
    apu_valid_i = 0;
    lsu_waddr_i = 22; lsu_wdata_i = 32'h1000_0022;
    check_eq("bp_lsu_full", lsu_ready_o, 0);
    tick();
    check_eq("bp_lsu_ready", lsu_ready_o, 1);
    tick();
    lsu_valid_i = 0;
    repeat (4) tick();
    ex_valid_i = 0;
    repeat (3) tick();
    check_eq("bp_drain_l", exp_l.size(), 0);
    check_eq("bp_drain_p", exp_p.size(), 0);
    check_eq("bp_drain_e", exp_e.size(), 0);

    // Random traffic over a small address set to provoke collisions and zero addresses.
    seq_l = 0; seq_p = 0;
    for (int c = 0; c < 400; c++) begin
      ex_valid_i = ($urandom_range(0, 2) == 0);
      ex_waddr_i = 6'($urandom_range(0, 7));
      ex_wdata_i = {4'hE, 28'(c)};
      acc_l = lsu_valid_i && lsu_ready_o;
      acc_p = apu_valid_i && apu_ready_o;
      tick();
      if (acc_l || !lsu_valid_i) begin
        lsu_valid_i = 1'($urandom_range(0, 1));
        lsu_waddr_i = 6'($urandom_range(0, 7));
        lsu_wdata_i = {4'h1, 28'(seq_l)};
        seq_l++;
      end
      if (acc_p || !apu_valid_i) begin
        apu_valid_i = 1'($urandom_range(0, 1));
        apu_waddr_i = 6'($urandom_range(0, 7));
        apu_wdata_i = {4'h2, 28'(seq_p)};
        seq_p++;
      end
    end
    clear_inputs();
    repeat (8) tick();
    check_eq("rnd_drain_l", exp_l.size(), 0);
    check_eq("rnd_drain_p", exp_p.size(), 0);
    check_eq("rnd_drain_e", exp_e.size(), 0);
    check_eq("rnd_pending", pending_o, 0);
    sb_en = 0;

    // Fill both FIFOs behind a permanent collision, then reset asynchronously.
    do_reset();
    ex_valid_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'hE5;
    lsu_valid_i = 1; lsu_waddr_i = 5; lsu_wdata_i = 32'h15;
    apu_valid_i = 1; apu_waddr_i = 5; apu_wdata_i = 32'h25;
    tick();
    tick();
    check_eq("full_lsu_rdy", lsu_ready_o, 0);
    check_eq("full_apu_rdy", apu_ready_o, 0);
    check_eq("full_pending", pending_o, 1);
    check_eq("full_wait", wait_cnt_o, 1);
    check_eq("full_we", {we_a_o, we_b_o}, 2'b10);
    rst_n = 0;
    #1;
    check_eq("arst_we", {we_a_o, we_b_o}, 2'b00);
    check_eq("arst_waddr_a", waddr_a_o, 0);
    check_eq("arst_wdata_a", wdata_a_o, 0);
    check_eq("arst_wait", wait_cnt_o, 0);
    check_eq("arst_pending", pending_o, 0);
    check_eq("arst_rdy", {lsu_ready_o, apu_ready_o}, 2'b11);
    clear_inputs();
    @(negedge clk_int);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("post_rst_we", {we_a_o, we_b_o}, 2'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
